// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: splits misaligned accesses into
// two word transactions, drives byte enables / shifted store data, extends loads.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] t);
        case (t[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Reserved encodings and unsigned-store encodings never reach memory
    function automatic logic is_bad(input logic we, input logic [2:0] t);
        is_bad = (t[1:0] == 2'b11) || (t[2] && t[1]) || (we && t[2]);
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] hi, input logic [31:0] lo,
                                                input logic [1:0] off, input logic [2:0] t);
        logic [31:0] v;
        v = 32'({hi, lo} >> {off, 3'b000});
        case (t)
            3'b000:  extend_load = {{24{v[7]}}, v[7:0]};
            3'b001:  extend_load = {{16{v[15]}}, v[15:0]};
            3'b100:  extend_load = {24'h000000, v[7:0]};
            3'b101:  extend_load = {16'h0000, v[15:0]};
            default: extend_load = v;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [31:0] addr_r, wdata_r, lo_r, hi_r, load_data_r;
    logic [31:0] addr_s, wdata_s, lo_s, hi_s, ld_s;
    logic        we_r, we_s, err_r, err_s, done_r;
    logic [2:0]  type_r, type_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic        accept_s, span_s, timeout_s;
    logic [1:0]  off_s;
    logic [7:0]  m8_s;
    logic        mem_req_r, mem_we_r, mem_req_s, mem_we_s;
    logic [29:0] mem_addr_r, mem_addr_s;
    logic [3:0]  mem_be_r, mem_be_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;

    assign stall     = req_valid & (state_r != DONE);
    assign done      = done_r;
    assign err       = err_r;
    assign load_data = load_data_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

    // Request view: the incoming request on acceptance, otherwise the latched one
    always_comb begin
        accept_s  = (state_r == IDLE) && req_valid;
        addr_s    = accept_s ? req_addr  : addr_r;
        wdata_s   = accept_s ? req_wdata : wdata_r;
        we_s      = accept_s ? req_we    : we_r;
        type_s    = accept_s ? req_type  : type_r;
        off_s     = addr_s[1:0];
        m8_s      = {4'b0000, size_mask(type_s)} << off_s;
        span_s    = (m8_s[7:4] != 4'b0000);
        timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) && !mem_ready;
    end

    // Next-state, capture and completion logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        lo_s    = lo_r;
        hi_s    = hi_r;
        err_s   = err_r;
        ld_s    = load_data_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (is_bad(req_we, req_type)) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                        ld_s    = 32'h0000_0000;
                    end else begin
                        state_s = ACC0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACC0: begin
                if (mem_ready) begin
                    lo_s  = mem_rdata;
                    cnt_s = {CNT_W{1'b0}};
                    if (span_s) begin
                        state_s = ACC1;
                    end else begin
                        state_s = DONE;
                        err_s   = 1'b0;
                        ld_s    = we_r ? 32'h0000_0000 : extend_load(hi_r, mem_rdata, off_s, type_r);
                    end
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                    ld_s    = 32'h0000_0000;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ACC1: begin
                if (mem_ready) begin
                    hi_s    = mem_rdata;
                    state_s = DONE;
                    err_s   = 1'b0;
                    ld_s    = we_r ? 32'h0000_0000 : extend_load(mem_rdata, lo_r, off_s, type_r);
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                    ld_s    = 32'h0000_0000;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Memory port values for the state being entered, so the port is registered
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = 30'd0;
        mem_be_s    = 4'b0000;
        mem_wdata_s = 32'h0000_0000;
        case (state_s)
            ACC0: begin
                mem_req_s   = 1'b1;
                mem_we_s    = we_s;
                mem_addr_s  = addr_s[31:2];
                mem_be_s    = m8_s[3:0];
                mem_wdata_s = wdata_s << {off_s, 3'b000};
            end
            ACC1: begin
                mem_req_s   = 1'b1;
                mem_we_s    = we_s;
                mem_addr_s  = addr_s[31:2] + 30'd1;
                mem_be_s    = m8_s[7:4];
                // (0 - off) mod 4 == 4 - off for the split offsets 1..3
                mem_wdata_s = wdata_s >> {2'd0 - off_s, 3'b000};
            end
            default: mem_req_s = 1'b0;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            we_r        <= 1'b0;
            type_r      <= 3'b000;
            lo_r        <= 32'h0000_0000;
            hi_r        <= 32'h0000_0000;
            cnt_r       <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            load_data_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 30'd0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            we_r        <= we_s;
            type_r      <= type_s;
            lo_r        <= lo_s;
            hi_r        <= hi_s;
            cnt_r       <= cnt_s;
            err_r       <= err_s;
            load_data_r <= ld_s;
            done_r      <= (state_s == DONE);
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_be_r    <= mem_be_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, timeout/reset sequences and
// randomized traffic checked against a byte-addressed memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] load_data, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;

    mem_access_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done), .err(err),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } tx_t;

    logic [31:0] mem [16];
    tx_t         log_a [1024];
    int          tx_n = 0, wait_cnt = 0, req_cyc = 0, zero_run = 0;
    int          rdy_mode = 0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'h0;
    logic [7:0]  ref_mem [64];
    int          n_vec = 0, n_miss = 0;

    // Memory responder: ready policy chosen on the falling edge
    always @(negedge clk) begin
        if (mem_req && rdy_mode == 0) begin
            mem_ready <= 1'b1;
        end else if (mem_req && rdy_mode == 1) begin
            if (zero_run >= 2 || $urandom_range(0, 2) != 0) begin
                mem_ready <= 1'b1;
                zero_run  <= 0;
            end else begin
                mem_ready <= 1'b0;
                zero_run  <= zero_run + 1;
            end
        end else begin
            mem_ready <= 1'b0;
        end
    end

    assign mem_rdata = mem_ready ? mem[mem_addr[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_req) req_cyc <= req_cyc + 1;
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_ready) begin
            log_a[tx_n % 1024] <= '{a: mem_addr, be: mem_be, we: mem_we, wd: mem_wdata};
            tx_n <= tx_n + 1;
        end
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_req && mem_ready && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        tick();
        pre_en = 1'b0;
    endtask

    // Issue one request, scramble the inputs mid-access, wait (bounded) for done
    task automatic run_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, output int cyc, output logic [31:0] ld,
                           output logic e);
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
        cyc = 0;
        #1;
        chk("stall_on_accept", {31'd0, stall}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (cyc == 1) begin
                req_addr = $urandom; req_wdata = $urandom;
                req_type = 3'($urandom); req_we = ~we;
            end
        end
        ld = load_data;
        e  = err;
        chk("stall_in_done", {31'd0, stall}, 32'd0);
        req_valid = 1'b0;
        tick();
    endtask

    function automatic int nbytes(input logic [2:0] t);
        return (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic type_ok(input logic we, input logic [2:0] t);
        return (t == 3'd0 || t == 3'd1 || t == 3'd2) || (!we && (t == 3'd4 || t == 3'd5));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(t);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a[5:0]) + i) % 64];
        if (t == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    typedef struct {
        logic        we;
        logic [2:0]  t;
        logic [31:0] a, wd, lo, hi, ld;
        logic        e;
        int          cyc, ntx;
        logic [29:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
    } vec_t;

    vec_t vt [12];

    initial begin
        int          cyc, tx0, w0, c0;
        logic [31:0] ld, xw;
        logic        e;

        vt[0]  = '{1'b0, 3'd2, 32'h0000_1000, 32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 30'h400, 30'h0, 4'b1111, 4'b0000, 32'h0, 32'h0};
        vt[1]  = '{1'b0, 3'd0, 32'h0000_0003, 32'h0, 32'h9A00_0000, 32'h0, 32'hFFFF_FF9A, 1'b0, 2, 1, 30'h0, 30'h0, 4'b1000, 4'b0000, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 3'd4, 32'h0000_0003, 32'h0, 32'h9A00_0000, 32'h0, 32'h0000_009A, 1'b0, 2, 1, 30'h0, 30'h0, 4'b1000, 4'b0000, 32'h0, 32'h0};
        vt[3]  = '{1'b0, 3'd1, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 32'h1122_33F4, 32'hFFFF_F480, 1'b0, 3, 2, 30'h400, 30'h401, 4'b1000, 4'b0001, 32'h0, 32'h0};
        vt[4]  = '{1'b0, 3'd5, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 32'h1122_33F4, 32'h0000_F480, 1'b0, 3, 2, 30'h400, 30'h401, 4'b1000, 4'b0001, 32'h0, 32'h0};
        vt[5]  = '{1'b1, 3'd2, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 3, 2, 30'h800, 30'h801, 4'b1100, 4'b0011, 32'hBEEF_0000, 32'h0000_DEAD};
        vt[6]  = '{1'b0, 3'd3, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 30'h0, 30'h0, 4'b0000, 4'b0000, 32'h0, 32'h0};
        vt[7]  = '{1'b1, 3'd4, 32'h0000_0010, 32'h55, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 30'h0, 30'h0, 4'b0000, 4'b0000, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h8001_0000, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1, 30'h0, 30'h0, 4'b1100, 4'b0000, 32'h0, 32'h0};
        vt[9]  = '{1'b0, 3'd2, 32'hFFFF_FFFD, 32'h0, 32'h4433_2211, 32'h8877_6655, 32'h5544_3322, 1'b0, 3, 2, 30'h3FFF_FFFF, 30'h0, 4'b1110, 4'b0001, 32'h0, 32'h0};
        vt[10] = '{1'b1, 3'd1, 32'h0000_0005, 32'hABCD_1234, 32'h0, 32'h0, 32'h0, 1'b0, 2, 1, 30'h1, 30'h0, 4'b0110, 4'b0000, 32'hCD12_3400, 32'h0};
        vt[11] = '{1'b0, 3'd2, 32'h0000_0007, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44AA, 1'b0, 3, 2, 30'h1, 30'h2, 4'b1000, 4'b0111, 32'h0, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        tick(); tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_port", {mem_we, mem_be, mem_addr[26:0]}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

        // Directed vector table, memory always ready
        rdy_mode = 0;
        foreach (vt[i]) begin
            preload(vt[i].a[5:2], vt[i].lo);
            preload(vt[i].a[5:2] + 4'd1, vt[i].hi);
            tx0 = tx_n;
            run_req(vt[i].we, vt[i].t, vt[i].a, vt[i].wd, cyc, ld, e);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_load_data", i), ld, vt[i].ld);
            chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vt[i].e});
            chk($sformatf("v%0d_ntx", i), tx_n - tx0, vt[i].ntx);
            for (int k = 0; k < vt[i].ntx && k < tx_n - tx0; k++) begin
                chk($sformatf("v%0d_tx%0d_addr", i, k), {2'b00, log_a[(tx0+k)%1024].a}, {2'b00, (k == 0) ? vt[i].a0 : vt[i].a1});
                chk($sformatf("v%0d_tx%0d_be", i, k), {28'd0, log_a[(tx0+k)%1024].be}, {28'd0, (k == 0) ? vt[i].be0 : vt[i].be1});
                chk($sformatf("v%0d_tx%0d_we", i, k), {31'd0, log_a[(tx0+k)%1024].we}, {31'd0, vt[i].we});
                chk($sformatf("v%0d_tx%0d_wdata", i, k), log_a[(tx0+k)%1024].wd, (k == 0) ? vt[i].wd0 : vt[i].wd1);
            end
        end

        // Timeout: memory never ready, request held for TIMEOUT_CYC cycles
        rdy_mode = 2;
        c0 = req_cyc;
        run_req(1'b0, 3'd2, 32'h0000_0000, 32'h0, cyc, ld, e);
        chk("timeout_cycles", cyc, 5);
        chk("timeout_req_cycles", req_cyc - c0, 4);
        chk("timeout_err", {31'd0, e}, 32'd1);
        chk("timeout_load_data", ld, 32'h0);
        chk("timeout_mem_req_dropped", {31'd0, mem_req}, 32'd0);

        // Reset during the second half of a split access
        rdy_mode = 0;
        req_valid = 1'b1; req_we = 1'b0; req_type = 3'd1; req_addr = 32'h0000_1003; req_wdata = 32'h0;
        tick(); tick();
        chk("rst_mid_in_acc1", {28'd0, mem_be}, 32'h1);
        rst = 1'b1; req_valid = 1'b0;
        tick();
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_mid_no_done", {31'd0, done}, 32'd0);
        preload(4'd0, 32'hCAFE_F00D);
        run_req(1'b0, 3'd2, 32'h0000_1000, 32'h0, cyc, ld, e);
        chk("post_rst_cycles", cyc, 2);
        chk("post_rst_load_data", ld, 32'hCAFE_F00D);
        chk("post_rst_err", {31'd0, e}, 32'd0);

        // Randomized traffic against the byte-level memory model
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = mem[w][8*b +: 8];
        rdy_mode = 1;
        for (int it = 0; it < 200; it++) begin
            logic        rwe;
            logic [2:0]  rt;
            logic [31:0] ra, rwd;
            int          n, exp_cyc;
            rwe = 1'($urandom);
            rt  = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!rwe && $urandom_range(0, 2) == 0) rt = 3'($urandom_range(4, 5));
            ra  = $urandom;
            rwd = $urandom;
            n   = nbytes(rt);
            w0  = wait_cnt;
            run_req(rwe, rt, ra, rwd, cyc, ld, e);
            if (!type_ok(rwe, rt)) begin
                exp_cyc = 1;
            end else begin
                exp_cyc = (((int'(ra[1:0]) + n) > 4) ? 3 : 2) + (wait_cnt - w0);
            end
            chk($sformatf("rnd%0d_cycles", it), cyc, exp_cyc);
            chk($sformatf("rnd%0d_err", it), {31'd0, e}, {31'd0, !type_ok(rwe, rt)});
            chk($sformatf("rnd%0d_load_data", it), ld,
                (type_ok(rwe, rt) && !rwe) ? model_load(rt, ra) : 32'h0);
            if (type_ok(rwe, rt) && rwe)
                for (int i = 0; i < n; i++) ref_mem[(int'(ra[5:0]) + i) % 64] = rwd[8*i +: 8];
        end
        for (int w = 0; w < 16; w++) begin
            xw = {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
            chk($sformatf("final_mem%0d", w), mem[w], xw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
